// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction fetch unit: word width, reset vector,
// FSM state encoding and fetch timeout limit.
package instr_fetch_pkg;

   localparam int unsigned WORD_W        = 16;
   localparam int unsigned WAIT_W        = 4;
   localparam int unsigned TIMEOUT_LIMIT = 16;

   typedef logic [WORD_W-1:0] word_t;

   localparam word_t RESET_VECTOR = 16'h0000;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_FETCH = 2'd1;
   localparam logic [1:0] ST_READY = 2'd2;

endpackage

// File: rtl/pc_counter.sv
// Program counter register: async reset to the reset vector, load has
// priority over increment, increment wraps modulo 2^WORD_W.
module pc_counter
   import instr_fetch_pkg::*;
(
   input  logic  clk,
   input  logic  rst,
   input  logic  load,
   input  logic  inc,
   input  word_t load_val,
   output word_t pc
);

   word_t pc_q;
   word_t pc_d;

   always_comb begin
      pc_d = pc_q;
      if (load) begin
         pc_d = load_val;
      end else if (inc) begin
         pc_d = pc_q + word_t'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q <= RESET_VECTOR;
      end else begin
         pc_q <= pc_d;
      end
   end

   assign pc = pc_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: IDLE/FETCH/READY FSM, RAM read handshake and IR.
// Define FETCH_TIMEOUT_EN to enable the 16-cycle fetch timeout and sticky fetch_err.
module instr_fetch
   import instr_fetch_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              pc_enable,
   input  logic              instr_enable,
   input  logic              pcin,
   input  logic [WORD_W-1:0] bus_in,
   output logic [WORD_W-1:0] mem_addr,
   output logic              mem_rd,
   input  logic              mem_ack,
   input  logic [WORD_W-1:0] mem_rdata,
   output logic [WORD_W-1:0] instr,
   output logic              instr_valid,
   output logic [WORD_W-1:0] pc,
   output logic              fetch_err
);

   logic [1:0] state_q, state_d;
   logic       mem_rd_q, mem_rd_d;
   word_t      mem_addr_q, mem_addr_d;
   word_t      instr_q, instr_d;
   logic       instr_valid_q, instr_valid_d;
   logic       pc_inc;
   logic       timeout;
   word_t      pc_cur;

   // An ack only counts while a request is actually on the bus.
   logic ack_seen;
   assign ack_seen = (state_q == ST_FETCH) && mem_rd_q && mem_ack;

`ifdef FETCH_TIMEOUT_EN
   localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT_LIMIT - 1);

   logic [WAIT_W-1:0] wait_q, wait_d;
   logic              fetch_err_q, fetch_err_d;

   assign timeout = (state_q == ST_FETCH) && mem_rd_q && !mem_ack && !pcin
                    && (wait_q == WAIT_MAX);

   always_comb begin
      wait_d      = '0;
      fetch_err_d = fetch_err_q | timeout;
      if ((state_q == ST_FETCH) && mem_rd_q && !mem_ack && !pcin && !timeout) begin
         wait_d = wait_q + WAIT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wait_q      <= '0;
         fetch_err_q <= 1'b0;
      end else begin
         wait_q      <= wait_d;
         fetch_err_q <= fetch_err_d;
      end
   end

   assign fetch_err = fetch_err_q;
`else
   assign timeout   = 1'b0;
   assign fetch_err = 1'b0;
`endif

   always_comb begin
      state_d       = state_q;
      mem_rd_d      = mem_rd_q;
      mem_addr_d    = mem_addr_q;
      instr_d       = instr_q;
      instr_valid_d = instr_valid_q;
      pc_inc        = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (!pcin && pc_enable) begin
               state_d    = ST_FETCH;
               mem_rd_d   = 1'b1;
               mem_addr_d = pc_cur;
            end
         end
         ST_FETCH: begin
            // A jump drops the request for one cycle; the re-issue picks up the new pc.
            if (pcin) begin
               mem_rd_d = 1'b0;
            end else if (!mem_rd_q) begin
               mem_rd_d   = 1'b1;
               mem_addr_d = pc_cur;
            end else if (ack_seen) begin
               if (instr_enable) begin
                  instr_d       = mem_rdata;
                  instr_valid_d = 1'b1;
                  pc_inc        = 1'b1;
                  mem_rd_d      = 1'b0;
                  state_d       = ST_READY;
               end
            end else if (timeout) begin
               mem_rd_d = 1'b0;
               state_d  = ST_IDLE;
            end
         end
         ST_READY: begin
            if (!pcin && pc_enable) begin
               state_d       = ST_FETCH;
               instr_valid_d = 1'b0;
               mem_rd_d      = 1'b1;
               mem_addr_d    = pc_cur;
            end
         end
         default: begin
            state_d  = ST_IDLE;
            mem_rd_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         mem_rd_q      <= 1'b0;
         mem_addr_q    <= '0;
         instr_q       <= '0;
         instr_valid_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         mem_rd_q      <= mem_rd_d;
         mem_addr_q    <= mem_addr_d;
         instr_q       <= instr_d;
         instr_valid_q <= instr_valid_d;
      end
   end

   pc_counter u_pc_counter (
      .clk      (clk),
      .rst      (rst),
      .load     (pcin),
      .inc      (pc_inc),
      .load_val (bus_in),
      .pc       (pc_cur)
   );

   assign mem_rd      = mem_rd_q;
   assign mem_addr    = mem_addr_q;
   assign instr       = instr_q;
   assign instr_valid = instr_valid_q;
   assign pc          = pc_cur;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios with literal
// expectations, then randomized traffic against a behavioural model.
module tb_instr_fetch;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        pc_enable = 1'b0;
   logic        instr_enable = 1'b0;
   logic        pcin = 1'b0;
   logic [15:0] bus_in = '0;
   logic [15:0] mem_addr;
   logic        mem_rd;
   logic        mem_ack = 1'b0;
   logic [15:0] mem_rdata = '0;
   logic [15:0] instr;
   logic        instr_valid;
   logic [15:0] pc;
   logic        fetch_err;

   int n_checks = 0;
   int n_fail   = 0;

   instr_fetch dut (
      .clk          (clk),
      .rst          (rst),
      .pc_enable    (pc_enable),
      .instr_enable (instr_enable),
      .pcin         (pcin),
      .bus_in       (bus_in),
      .mem_addr     (mem_addr),
      .mem_rd       (mem_rd),
      .mem_ack      (mem_ack),
      .mem_rdata    (mem_rdata),
      .instr        (instr),
      .instr_valid  (instr_valid),
      .pc           (pc),
      .fetch_err    (fetch_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Behavioural model: "busy" means a fetch is in progress, "holding" means
   // the IR has an unconsumed instruction.
   logic [15:0] m_pc = '0, m_instr = '0, m_addr = '0;
   logic        m_busy = 1'b0, m_hold = 1'b0, m_rd = 1'b0, m_err = 1'b0;
   int          m_wait = 0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_pc <= '0; m_instr <= '0; m_addr <= '0;
         m_busy <= 1'b0; m_hold <= 1'b0; m_rd <= 1'b0; m_err <= 1'b0;
         m_wait <= 0;
      end else begin
         automatic logic [15:0] p = m_pc, ir = m_instr, a = m_addr;
         automatic logic        b = m_busy, h = m_hold, r = m_rd, e = m_err;
         automatic int          w = m_wait;
         if (pcin) begin
            p = bus_in;
            if (b) r = 1'b0;
            w = 0;
         end else if (b) begin
            if (!r) begin
               r = 1'b1; a = m_pc;
            end else if (mem_ack) begin
               w = 0;
               if (instr_enable) begin
                  ir = mem_rdata; p = 16'((32'(m_pc) + 1) % 65536);
                  h = 1'b1; b = 1'b0; r = 1'b0;
               end
            end else begin
`ifdef FETCH_TIMEOUT_EN
               w = w + 1;
               if (w == 16) begin
                  e = 1'b1; r = 1'b0; b = 1'b0; w = 0;
               end
`endif
            end
         end else if (pc_enable) begin
            b = 1'b1; h = 1'b0; r = 1'b1; a = m_pc;
         end
         m_pc <= p; m_instr <= ir; m_addr <= a;
         m_busy <= b; m_hold <= h; m_rd <= r; m_err <= e; m_wait <= w;
      end
   end

   // Continuous comparison against the model, away from the active edge.
   initial begin
      forever begin
         @(negedge clk);
         chk("cmp_pc", pc, m_pc);
         chk("cmp_instr", instr, m_instr);
         chk("cmp_instr_valid", 16'(instr_valid), 16'(m_hold));
         chk("cmp_mem_rd", 16'(mem_rd), 16'(m_rd));
         if (m_rd) chk("cmp_mem_addr", mem_addr, m_addr);
         chk("cmp_fetch_err", 16'(fetch_err), 16'(m_err));
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_pc"}, pc, 16'h0000);
      chk({tag, "_instr"}, instr, 16'h0000);
      chk({tag, "_valid"}, 16'(instr_valid), 16'h0000);
      chk({tag, "_mem_rd"}, 16'(mem_rd), 16'h0000);
      chk({tag, "_mem_addr"}, mem_addr, 16'h0000);
      chk({tag, "_fetch_err"}, 16'(fetch_err), 16'h0000);
   endtask

   initial begin
      cyc();
      chk_reset_vals("reset");
      rst = 1'b0;

      // Basic fetch with ack two cycles after the request.
      pc_enable = 1'b1; instr_enable = 1'b1;
      cyc();
      chk("fetch1_mem_rd", 16'(mem_rd), 16'h0001);
      chk("fetch1_addr", mem_addr, 16'h0000);
      pc_enable = 1'b0;
      cyc(); cyc();
      chk("fetch1_wait_rd", 16'(mem_rd), 16'h0001);
      mem_ack = 1'b1; mem_rdata = 16'h1234;
      cyc();
      mem_ack = 1'b0;
      chk("fetch1_instr", instr, 16'h1234);
      chk("fetch1_valid", 16'(instr_valid), 16'h0001);
      chk("fetch1_pc", pc, 16'h0001);
      chk("fetch1_rd_low", 16'(mem_rd), 16'h0000);

      // PC wrap from 0xFFFF.
      pcin = 1'b1; bus_in = 16'hFFFF;
      cyc();
      pcin = 1'b0;
      chk("wrap_load_pc", pc, 16'hFFFF);
      chk("wrap_load_valid", 16'(instr_valid), 16'h0001);
      pc_enable = 1'b1;
      cyc();
      pc_enable = 1'b0;
      chk("wrap_addr", mem_addr, 16'hFFFF);
      chk("wrap_valid_cleared", 16'(instr_valid), 16'h0000);
      mem_ack = 1'b1; mem_rdata = 16'hBEEF;
      cyc();
      mem_ack = 1'b0;
      chk("wrap_pc", pc, 16'h0000);
      chk("wrap_valid", 16'(instr_valid), 16'h0001);
      chk("wrap_instr", instr, 16'hBEEF);

      // Jump coincident with ack.
      pc_enable = 1'b1;
      cyc();
      pc_enable = 1'b0;
      mem_ack = 1'b1; mem_rdata = 16'h5555; pcin = 1'b1; bus_in = 16'h0040;
      cyc();
      mem_ack = 1'b0; pcin = 1'b0;
      chk("jump_ack_instr", instr, 16'hBEEF);
      chk("jump_ack_valid", 16'(instr_valid), 16'h0000);
      chk("jump_ack_rd_drop", 16'(mem_rd), 16'h0000);
      chk("jump_ack_pc", pc, 16'h0040);
      cyc();
      chk("jump_reissue_rd", 16'(mem_rd), 16'h0001);
      chk("jump_reissue_addr", mem_addr, 16'h0040);

      // Ack refused by instr_enable=0.
      instr_enable = 1'b0; mem_ack = 1'b1; mem_rdata = 16'h7777;
      cyc();
      mem_ack = 1'b0; instr_enable = 1'b1;
      chk("noie_pc", pc, 16'h0040);
      chk("noie_rd", 16'(mem_rd), 16'h0001);
      chk("noie_addr", mem_addr, 16'h0040);
      chk("noie_instr", instr, 16'hBEEF);

      // Reset mid-fetch, then a late ack.
      cyc();
      #2 rst = 1'b1;
      #1 chk_reset_vals("async_rst");
      cyc();
      rst = 1'b0;
      mem_ack = 1'b1; mem_rdata = 16'h9999;
      cyc();
      mem_ack = 1'b0;
      chk_reset_vals("late_ack");

      // No ack for a long stretch.
      pc_enable = 1'b1;
      cyc();
      pc_enable = 1'b0;
`ifdef FETCH_TIMEOUT_EN
      for (int i = 0; i < 15; i++) begin
         cyc();
         chk("to_wait_rd", 16'(mem_rd), 16'h0001);
      end
      cyc();
      chk("to_rd_low", 16'(mem_rd), 16'h0000);
      chk("to_err", 16'(fetch_err), 16'h0001);
      for (int i = 0; i < 3; i++) cyc();
      chk("to_idle_rd", 16'(mem_rd), 16'h0000);
      chk("to_err_sticky", 16'(fetch_err), 16'h0001);
      pc_enable = 1'b1;
      cyc();
      pc_enable = 1'b0;
      chk("to_restart_rd", 16'(mem_rd), 16'h0001);
      mem_ack = 1'b1; mem_rdata = 16'h0ABC;
      cyc();
      mem_ack = 1'b0;
      chk("to_err_after_fetch", 16'(fetch_err), 16'h0001);
      chk("to_instr_after", instr, 16'h0ABC);
`else
      for (int i = 0; i < 20; i++) begin
         cyc();
         chk("nto_wait_rd", 16'(mem_rd), 16'h0001);
         chk("nto_err", 16'(fetch_err), 16'h0000);
      end
`endif
      rst = 1'b1;
      cyc();
      chk_reset_vals("rst_clear");
      rst = 1'b0;

      // Randomized traffic; the compare process checks every cycle.
      for (int n = 0; n < 4000; n++) begin
         rst          = 1'b0;
         pc_enable    = ($urandom_range(0, 1) == 1);
         instr_enable = ($urandom_range(0, 3) != 0);
         pcin         = ($urandom_range(0, 9) == 0);
         mem_ack      = ($urandom_range(0, 4) < 2);
         mem_rdata    = 16'($urandom);
         case ($urandom_range(0, 3))
            0:       bus_in = 16'hFFFF;
            1:       bus_in = 16'hFFFE;
            default: bus_in = 16'($urandom);
         endcase
         if ($urandom_range(0, 199) == 0) begin
            #2 rst = 1'b1;
         end
         cyc();
      end
      rst = 1'b0; pc_enable = 1'b0; pcin = 1'b0; mem_ack = 1'b0;
      cyc(); cyc();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst  input  1  asynchronous, active-high reset.
REQ-003 pc_enable  input  1  from control unit: request the next instruction fetch.
REQ-004 instr_enable  input  1  from control unit: permission to capture fetched word into the IR.
REQ-005 pcin  input  1  load PC from bus_in this cycle (jump/branch).
REQ-006 bus_in  input  16  datapath bus value for PC load.
REQ-007 mem_addr  output  16  RAM read address (equals PC while mem_rd high).
REQ-008 mem_rd  output  1  RAM read request, held until acknowledged.
REQ-009 mem_ack  input  1  RAM read acknowledge; mem_rdata valid in the same cycle.
REQ-010 mem_rdata  input  16  RAM read data.
REQ-011 instr  output  16  instruction register; feeds the control unit instr input.
REQ-012 instr_valid  output  1  instr holds a freshly fetched, unconsumed instruction.
REQ-013 pc  output  16  current program counter (next fetch address).
REQ-014 fetch_err  output  1  sticky fetch-timeout flag (present only with FETCH_TIMEOUT_EN).

Function
REQ-015 FSM states SHALL be IDLE, FETCH, READY; all outputs registered.
REQ-016 IDLE: mem_rd=0; pc_enable=1 -> FETCH next cycle.
REQ-017 FETCH: mem_rd=1, mem_addr=pc, held until mem_ack sampled high.
REQ-018 FETCH with mem_ack=1 and instr_enable=1: instr<=mem_rdata, pc<=pc+1, instr_valid<=1, -> READY.
REQ-019 FETCH with mem_ack=1 and instr_enable=0: data discarded, pc unchanged, stay FETCH (re-request same address).
REQ-020 READY: instr_valid=1, mem_rd=0; pc_enable=1 -> instr_valid<=0, -> FETCH.
REQ-021 Fetch latency SHALL be 1 cycle from pc_enable to mem_rd, 1 cycle from mem_ack to instr_valid.
REQ-022 PC increment SHALL be modulo 2^16: 0xFFFF wraps to 0x0000, no flag.
REQ-023 pcin=1 in any state: pc<=bus_in next cycle; pcin has priority over increment.
REQ-024 pcin=1 coincident with mem_ack in FETCH: fetched word discarded, instr/instr_valid unchanged, stay FETCH, next request uses new pc.
REQ-025 pcin=1 in FETCH without ack: mem_rd drops one cycle, then re-asserts at new pc.
REQ-026 pcin=1 in IDLE/READY: state and instr_valid unchanged.
REQ-027 mem_ack outside FETCH SHALL be ignored.

Reset
REQ-028 rst high: state=IDLE, pc=0x0000, instr=0x0000, instr_valid=0, mem_rd=0, mem_addr=0x0000, fetch_err=0, wait counter=0, immediately and independent of clk.
REQ-029 rst during outstanding FETCH SHALL abandon the request; a later mem_ack in IDLE is ignored.

Configuration
REQ-030 Macro FETCH_TIMEOUT_EN defined: 4-bit wait counter counts FETCH cycles without ack; at 16 cycles fetch_err<=1 (sticky to reset), mem_rd<=0, -> IDLE; counter clears on leaving FETCH or pcin.
REQ-031 Macro undefined: no counter, FETCH waits indefinitely, fetch_err port tied to 0.

Structure
REQ-032 Shared package SHALL hold: word width (16), reset vector (0x0000), FSM state encoding, timeout limit (16).
REQ-033 One sub-module pc_counter (16-bit register with load/increment/async reset) SHALL hold the PC; FSM and IR stay in instr_fetch.

Verification
REQ-034 Reset then pc_enable, mem_ack after 2 cycles with rdata=0x1234 -> instr=0x1234, instr_valid=1, pc=0x0001.
REQ-035 pc=0xFFFF, complete fetch -> pc=0x0000, instr_valid=1.
REQ-036 pcin=1, bus_in=0x0040 in same cycle as mem_ack -> instr unchanged, instr_valid=0, next mem_addr=0x0040.
REQ-037 mem_ack with instr_enable=0 -> pc unchanged, mem_rd stays 1, same mem_addr re-requested.
REQ-038 rst asserted mid-FETCH, then late mem_ack -> all outputs at reset values, ack ignored.
REQ-039 FETCH_TIMEOUT_EN, no ack for 16 cycles -> fetch_err=1, mem_rd=0, state IDLE; fetch_err held until rst.
